frame_sequencer: RTL and testbench

Controller for the texture-ROM animation datapath. It selects which stored frame the pixel-fetch path reads. Frame advance is driven by a programmable period timer and can optionally be held until the next revolution boundary, so a frame never changes mid-sweep. The CPU configures it through the memory-mapped I/O write port; its outputs drive the frame index (and optional offset) into the ROM address adder.

---
 rtl/frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// ---------------------------------------------------------------------------
// frame_sequencer
// Selects the texture-ROM frame read by the pixel-fetch path. A period timer
// requests frame advances; with rev_sync set the advance is held until the
// next revolution boundary (rev_tick) so a frame never changes mid-sweep.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   cfg_we       config write strobe (one cycle)
//   cfg_addr     0=CTRL 1=PERIOD 2=FIRST 3=LAST
//   cfg_wdata    config write data
//   rev_tick     one-cycle pulse at theta wrap
//   frame_idx    current frame index
//   frame_strobe one-cycle pulse in the cycle frame_idx takes a new value
//   waiting      an advance is pending on rev_tick
//   frame_offset frame_idx*FRAME_SIZE (only with FRAME_SEQ_OFFSET_EN)
//
// CTRL: [0] run, [1] step (not stored), [2] pingpong, [3] rev_sync,
//       [4] reverse start direction
//
// Optional feature macro: FRAME_SEQ_OFFSET_EN adds the registered
// frame_offset output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | run=0, timer frozen, a step write may request one advance
// S_RUN     | timer counting, expiry advances (or defers to S_PENDING)
// S_PENDING | one advance held until rev_tick or rev_sync cleared
// ---------------------------------------------------------------------------
module frame_sequencer #(
  parameter int NUM_FRAMES     = 30,
  parameter int FRAME_SIZE     = 3328,
  parameter int IDX_W          = 8,
  parameter int TIMER_W        = 32,
  parameter int DEFAULT_PERIOD = 6666667
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             rev_tick,
  output logic [IDX_W-1:0] frame_idx,
  output logic             frame_strobe,
  output logic             waiting
`ifdef FRAME_SEQ_OFFSET_EN
  ,
  output logic [$clog2(FRAME_SIZE*NUM_FRAMES)-1:0] frame_offset
`endif
);

  localparam logic [IDX_W-1:0]   MAX_IDX    = IDX_W'(NUM_FRAMES - 1);
  localparam logic [TIMER_W-1:0] RST_PERIOD = TIMER_W'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PENDING} state_t;
  typedef enum logic [2:0] {MV_HOLD, MV_INC, MV_DEC, MV_FIRST, MV_LAST} move_t;

  state_t             state_q, state_n;
  logic               run_q, run_n, pp_q, pp_n, sync_q, sync_n, rev_q, rev_n;
  logic               dir_q, dir_n;  // 1 = counting down
  logic [TIMER_W-1:0] period_q, period_n, timer_q, timer_n, period_eff;
  logic [IDX_W-1:0]   first_q, first_n, last_q, last_n, last_eff;
  logic [IDX_W-1:0]   frame_idx_n, wdata_clamp, jump_idx;
  logic               strobe_n;
  logic               wr_ctrl, wr_period, wr_first, wr_last, jump;
  logic               counting, expire, adv, single;
  logic               dir_eff, pp_eff, adv_dir;
  move_t              mv;

  assign wr_ctrl   = cfg_we && (cfg_addr == 2'd0);
  assign wr_period = cfg_we && (cfg_addr == 2'd1);
  assign wr_first  = cfg_we && (cfg_addr == 2'd2);
  assign wr_last   = cfg_we && (cfg_addr == 2'd3);
  assign jump      = wr_first || wr_last;

  assign wdata_clamp = (cfg_wdata > 32'(NUM_FRAMES - 1)) ? MAX_IDX : cfg_wdata[IDX_W-1:0];
  assign jump_idx    = wr_first ? wdata_clamp : first_q;

  // FIRST > LAST collapses the range to the single frame FIRST.
  assign last_eff   = (first_q > last_q) ? first_q : last_q;
  assign single     = (first_q >= last_q);
  assign period_eff = (period_q == '0) ? TIMER_W'(1) : period_q;

  assign counting = run_q && (state_q != S_IDLE);
  assign expire   = counting && (timer_q == period_eff - TIMER_W'(1));

  assign waiting = (state_q == S_PENDING);

  // A step carried by a CTRL write uses the mode bits of that same write.
  always_comb begin : move_decode
    dir_eff = (wr_ctrl && (cfg_wdata[4] != rev_q)) ? cfg_wdata[4] : dir_q;
    pp_eff  = wr_ctrl ? cfg_wdata[2] : pp_q;
    mv      = MV_HOLD;
    adv_dir = dir_eff;
    if (single) begin
      mv = MV_HOLD;
    end else if (pp_eff) begin
      if (!dir_eff) begin
        if (frame_idx >= last_eff) begin
          mv      = MV_DEC;
          adv_dir = 1'b1;
        end else begin
          mv = MV_INC;
        end
      end else begin
        if (frame_idx <= first_q) begin
          mv      = MV_INC;
          adv_dir = 1'b0;
        end else begin
          mv = MV_DEC;
        end
      end
    end else if (!dir_eff) begin
      mv = (frame_idx >= last_eff) ? MV_FIRST : MV_INC;
    end else begin
      mv = (frame_idx <= first_q) ? MV_LAST : MV_DEC;
    end
  end

  always_comb begin : next_state
    state_n     = state_q;
    timer_n     = timer_q;
    run_n       = run_q;
    pp_n        = pp_q;
    sync_n      = sync_q;
    rev_n       = rev_q;
    dir_n       = dir_q;
    period_n    = period_q;
    first_n     = first_q;
    last_n      = last_q;
    frame_idx_n = frame_idx;
    strobe_n    = 1'b0;
    adv         = 1'b0;

    if (counting) begin
      timer_n = expire ? '0 : timer_q + TIMER_W'(1);
    end

    // Any config write in the cycle wins over an expiry or rev_tick advance.
    case (state_q)
      S_IDLE: begin
        if (run_q) begin
          state_n = S_RUN;
        end else if (wr_ctrl && cfg_wdata[1] && !cfg_wdata[0]) begin
          if (cfg_wdata[3]) state_n = S_PENDING;
          else              adv     = 1'b1;
        end
      end
      S_RUN: begin
        if (!run_q) begin
          state_n = S_IDLE;
        end else if (expire && !cfg_we) begin
          if (sync_q) state_n = S_PENDING;
          else        adv     = 1'b1;
        end
      end
      S_PENDING: begin
        if (!cfg_we && (rev_tick || !sync_q)) begin
          adv     = 1'b1;
          state_n = run_q ? S_RUN : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (wr_ctrl) begin
      run_n  = cfg_wdata[0];
      pp_n   = cfg_wdata[2];
      sync_n = cfg_wdata[3];
      rev_n  = cfg_wdata[4];
      if (cfg_wdata[4] != rev_q) dir_n = cfg_wdata[4];
    end

    if (adv) begin
      strobe_n = 1'b1;
      dir_n    = adv_dir;
      case (mv)
        MV_INC:   frame_idx_n = frame_idx + IDX_W'(1);
        MV_DEC:   frame_idx_n = frame_idx - IDX_W'(1);
        MV_FIRST: frame_idx_n = first_q;
        MV_LAST:  frame_idx_n = last_eff;
        default:  frame_idx_n = frame_idx;
      endcase
    end

    if (wr_period) begin
      period_n = TIMER_W'(cfg_wdata);
      timer_n  = '0;
    end

    if (jump) begin
      if (wr_first) first_n = wdata_clamp;
      if (wr_last)  last_n  = wdata_clamp;
      timer_n     = '0;
      frame_idx_n = jump_idx;
      dir_n       = rev_q;
      strobe_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      timer_q      <= '0;
      run_q        <= 1'b1;
      pp_q         <= 1'b0;
      sync_q       <= 1'b0;
      rev_q        <= 1'b0;
      dir_q        <= 1'b0;
      period_q     <= RST_PERIOD;
      first_q      <= '0;
      last_q       <= MAX_IDX;
      frame_idx    <= '0;
      frame_strobe <= 1'b0;
    end else begin
      state_q      <= state_n;
      timer_q      <= timer_n;
      run_q        <= run_n;
      pp_q         <= pp_n;
      sync_q       <= sync_n;
      rev_q        <= rev_n;
      dir_q        <= dir_n;
      period_q     <= period_n;
      first_q      <= first_n;
      last_q       <= last_n;
      frame_idx    <= frame_idx_n;
      frame_strobe <= strobe_n;
    end
  end

`ifdef FRAME_SEQ_OFFSET_EN
  localparam int               OFF_W = $clog2(FRAME_SIZE * NUM_FRAMES);
  localparam logic [OFF_W-1:0] FS    = OFF_W'(FRAME_SIZE);

  logic [OFF_W-1:0] offset_n;

  // Single steps add/subtract FRAME_SIZE; jumps scale a register by a
  // constant, which reduces to shifts and adds.
  always_comb begin : offset_next
    offset_n = frame_offset;
    if (jump) begin
      offset_n = OFF_W'(jump_idx) * FS;
    end else if (adv) begin
      case (mv)
        MV_INC:   offset_n = frame_offset + FS;
        MV_DEC:   offset_n = frame_offset - FS;
        MV_FIRST: offset_n = OFF_W'(first_q) * FS;
        MV_LAST:  offset_n = OFF_W'(last_eff) * FS;
        default:  offset_n = frame_offset;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_offset <= '0;
    else        frame_offset <= offset_n;
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        rev_tick = 1'b0;
  logic [7:0]  frame_idx;
  logic        frame_strobe;
  logic        waiting;
`ifdef FRAME_SEQ_OFFSET_EN
  logic [16:0] frame_offset;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit noise   = 1'b0;

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .rev_tick     (rev_tick),
    .frame_idx    (frame_idx),
    .frame_strobe (frame_strobe),
    .waiting      (waiting)
`ifdef FRAME_SEQ_OFFSET_EN
    ,
    .frame_offset (frame_offset)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Returns cycles until frame_strobe is seen, or -1 when the budget runs out.
  task automatic wait_strobe(input int budget, output int n);
    bit done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      if (noise) rev_tick = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (frame_strobe) done = 1'b1;
      else if (n >= budget) begin
        n = -1;
        done = 1'b1;
      end
    end
    rev_tick = 1'b0;
  endtask

  task automatic wait_waiting(input int budget, output int n);
    n = 0;
    while (!waiting && n < budget) begin
      tick();
      n++;
    end
    if (!waiting) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_total++; if (frame_idx !== 8'd0) $display("FAIL reset_idx got=%0d exp=0", frame_idx); else n_pass++;
    n_total++; if (frame_strobe !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", frame_strobe); else n_pass++;
    n_total++; if (waiting !== 1'b0) $display("FAIL reset_waiting got=%b exp=0", waiting); else n_pass++;
    reset = 1'b1;
    repeat (5) tick();
    n_total++; if (frame_idx !== 8'd0) $display("FAIL post_reset_idx got=%0d exp=0", frame_idx); else n_pass++;
  endtask

  task automatic test_loop();
    int n;
    cfg_write(2'd1, 32'd4);
    for (int k = 0; k < 30; k++) begin
      wait_strobe(20, n);
      n_total++; if (n !== 4) $display("FAIL loop_interval k=%0d got=%0d exp=4", k, n); else n_pass++;
      n_total++; if (frame_idx !== 8'((k + 1) % 30)) $display("FAIL loop_idx k=%0d got=%0d exp=%0d", k, frame_idx, (k + 1) % 30); else n_pass++;
    end
  endtask

  task automatic test_pingpong();
    int n;
    int exp_seq[5] = '{6, 7, 6, 5, 6};
    cfg_write(2'd0, 32'h05);
    cfg_write(2'd1, 32'd2);
    cfg_write(2'd2, 32'd5);
    cfg_write(2'd3, 32'd7);
    n_total++; if (frame_idx !== 8'd5 || frame_strobe !== 1'b1) $display("FAIL pp_jump idx=%0d strobe=%b exp idx=5 strobe=1", frame_idx, frame_strobe); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      wait_strobe(20, n);
      n_total++; if (n !== 2) $display("FAIL pp_interval k=%0d got=%0d exp=2", k, n); else n_pass++;
      n_total++; if (frame_idx !== 8'(exp_seq[k])) $display("FAIL pp_idx k=%0d got=%0d exp=%0d", k, frame_idx, exp_seq[k]); else n_pass++;
`ifdef FRAME_SEQ_OFFSET_EN
      if (exp_seq[k] == 7) begin
        n_total++; if (frame_offset !== 17'd23296) $display("FAIL pp_offset got=%0d exp=23296", frame_offset); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_rev_sync();
    int n;
    cfg_write(2'd1, 32'd3);
    cfg_write(2'd2, 32'd0);
    cfg_write(2'd3, 32'd29);
    cfg_write(2'd0, 32'h09);
    wait_waiting(10, n);
    n_total++; if (n < 0) $display("FAIL sync_wait_timeout waiting=%b exp=1", waiting); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_total++; if (waiting !== 1'b1 || frame_idx !== 8'd0) $display("FAIL sync_hold k=%0d waiting=%b idx=%0d exp waiting=1 idx=0", k, waiting, frame_idx); else n_pass++;
    end
    rev_tick = 1'b1;
    tick();
    rev_tick = 1'b0;
    n_total++; if (frame_idx !== 8'd1 || frame_strobe !== 1'b1 || waiting !== 1'b0) $display("FAIL sync_tick idx=%0d strobe=%b waiting=%b exp 1/1/0", frame_idx, frame_strobe, waiting); else n_pass++;
    rev_tick = 1'b1;
    tick();
    rev_tick = 1'b0;
    n_total++; if (frame_idx !== 8'd1 || frame_strobe !== 1'b0) $display("FAIL sync_stray_tick idx=%0d strobe=%b exp 1/0", frame_idx, frame_strobe); else n_pass++;
    wait_waiting(10, n);
    cfg_write(2'd0, 32'h01);
    n_total++; if (frame_idx !== 8'd1) $display("FAIL sync_clear_early idx=%0d exp=1", frame_idx); else n_pass++;
    tick();
    n_total++; if (frame_idx !== 8'd2 || frame_strobe !== 1'b1 || waiting !== 1'b0) $display("FAIL sync_clear idx=%0d strobe=%b waiting=%b exp 2/1/0", frame_idx, frame_strobe, waiting); else n_pass++;
  endtask

  task automatic test_step();
    cfg_write(2'd1, 32'd1000);
    cfg_write(2'd0, 32'h00);
    cfg_write(2'd2, 32'd3);
    cfg_write(2'd3, 32'd29);
    repeat (3) tick();
    n_total++; if (frame_idx !== 8'd3 || frame_strobe !== 1'b0) $display("FAIL step_idle idx=%0d strobe=%b exp 3/0", frame_idx, frame_strobe); else n_pass++;
    cfg_write(2'd0, 32'h02);
    n_total++; if (frame_idx !== 8'd4 || frame_strobe !== 1'b1) $display("FAIL step_adv idx=%0d strobe=%b exp 4/1", frame_idx, frame_strobe); else n_pass++;
    tick();
    n_total++; if (frame_idx !== 8'd4 || frame_strobe !== 1'b0) $display("FAIL step_single idx=%0d strobe=%b exp 4/0", frame_idx, frame_strobe); else n_pass++;
    cfg_write(2'd0, 32'h01);
    tick();
    cfg_write(2'd0, 32'h03);
    repeat (2) tick();
    n_total++; if (frame_idx !== 8'd4 || frame_strobe !== 1'b0) $display("FAIL step_while_run idx=%0d strobe=%b exp 4/0", frame_idx, frame_strobe); else n_pass++;
    cfg_write(2'd0, 32'h00);
    tick();
    cfg_write(2'd0, 32'h0A);
    repeat (3) tick();
    n_total++; if (waiting !== 1'b1 || frame_idx !== 8'd4) $display("FAIL step_sync_pending waiting=%b idx=%0d exp 1/4", waiting, frame_idx); else n_pass++;
    rev_tick = 1'b1;
    tick();
    rev_tick = 1'b0;
    n_total++; if (frame_idx !== 8'd5 || frame_strobe !== 1'b1 || waiting !== 1'b0) $display("FAIL step_sync_tick idx=%0d strobe=%b waiting=%b exp 5/1/0", frame_idx, frame_strobe, waiting); else n_pass++;
  endtask

  task automatic test_collision();
    int n;
    cfg_write(2'd0, 32'h01);
    tick();
    cfg_write(2'd1, 32'd5);
    repeat (4) tick();
    cfg_write(2'd1, 32'd5);
    n_total++; if (frame_idx !== 8'd5 || frame_strobe !== 1'b0) $display("FAIL collide_no_adv idx=%0d strobe=%b exp 5/0", frame_idx, frame_strobe); else n_pass++;
    wait_strobe(20, n);
    n_total++; if (n !== 5 || frame_idx !== 8'd6) $display("FAIL collide_timer_restart cycles=%0d idx=%0d exp 5/6", n, frame_idx); else n_pass++;
    cfg_write(2'd2, 32'd40);
    n_total++; if (frame_idx !== 8'd29 || frame_strobe !== 1'b1) $display("FAIL first_clamp idx=%0d strobe=%b exp 29/1", frame_idx, frame_strobe); else n_pass++;
  endtask

  task automatic test_reset_pending();
    int n;
    bit saw;
    cfg_write(2'd0, 32'h09);
    wait_waiting(20, n);
    n_total++; if (n < 0) $display("FAIL rp_wait_timeout waiting=%b exp=1", waiting); else n_pass++;
    repeat (2) tick();
    #3;
    reset = 1'b0;
    #1;
    n_total++; if (frame_idx !== 8'd0 || frame_strobe !== 1'b0 || waiting !== 1'b0) $display("FAIL rp_async idx=%0d strobe=%b waiting=%b exp 0/0/0", frame_idx, frame_strobe, waiting); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (frame_strobe || waiting) saw = 1'b1;
    end
    n_total++; if (saw !== 1'b0 || frame_idx !== 8'd0) $display("FAIL rp_default_period activity=%b idx=%0d exp 0/0", saw, frame_idx); else n_pass++;
    cfg_write(2'd1, 32'd2);
    wait_strobe(20, n);
    n_total++; if (n !== 2 || frame_idx !== 8'd1 || waiting !== 1'b0) $display("FAIL rp_resume cycles=%0d idx=%0d waiting=%b exp 2/1/0", n, frame_idx, waiting); else n_pass++;
  endtask

  // Reference: the frame order over one full cycle of the range, as a list.
  task automatic test_random();
    int n, f_raw, l_raw, f, l, per, pe;
    bit pp, rv;
    int seq[$];
    for (int it = 0; it < 6; it++) begin
      f_raw = $urandom_range(0, 35);
      l_raw = $urandom_range(0, 35);
      pp    = 1'($urandom_range(0, 1));
      rv    = 1'($urandom_range(0, 1));
      per   = $urandom_range(0, 6);
      f  = (f_raw > 29) ? 29 : f_raw;
      l  = (l_raw > 29) ? 29 : l_raw;
      pe = (per == 0) ? 1 : per;
      seq.delete();
      if (l <= f) seq.push_back(f);
      else if (pp) begin
        for (int v = f; v <= l; v++) seq.push_back(v);
        for (int v = l - 1; v > f; v--) seq.push_back(v);
      end else if (!rv) begin
        for (int v = f; v <= l; v++) seq.push_back(v);
      end else begin
        seq.push_back(f);
        for (int v = l; v > f; v--) seq.push_back(v);
      end
      cfg_write(2'd0, 32'h01 | (32'(pp) << 2) | (32'(rv) << 4));
      cfg_write(2'd1, 32'(per));
      cfg_write(2'd2, 32'(f_raw));
      cfg_write(2'd3, 32'(l_raw));
      n_total++; if (frame_idx !== 8'(f)) $display("FAIL rnd_start it=%0d got=%0d exp=%0d", it, frame_idx, f); else n_pass++;
      noise = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        wait_strobe(20, n);
        n_total++; if (n !== pe) $display("FAIL rnd_interval it=%0d k=%0d got=%0d exp=%0d", it, k, n, pe); else n_pass++;
        n_total++; if (frame_idx !== 8'(seq[k % seq.size()])) $display("FAIL rnd_idx it=%0d k=%0d got=%0d exp=%0d", it, k, frame_idx, seq[k % seq.size()]); else n_pass++;
`ifdef FRAME_SEQ_OFFSET_EN
        n_total++; if (frame_offset !== 17'(seq[k % seq.size()] * 3328)) $display("FAIL rnd_offset it=%0d got=%0d exp=%0d", it, frame_offset, seq[k % seq.size()] * 3328); else n_pass++;
`endif
      end
      noise = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_pingpong();
    test_rev_sync();
    test_step();
    test_collision();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
